pal_cfg_loader: RTL
===================

// Module: pal_cfg_loader
// PURPOSE
//   Byte-wide configuration sequencer for the PAL fabric. Accepts the bitstream as bytes over a
//   valid/ready port and serialises it LSB-first into the PAL scan chain (pal_cfg + pal_shift).
//   Counts exactly CFG_LEN bits, then asserts pal_en to apply the configuration. Sits between the
//   chip-level IO wrapper and the PAL instance; replaces manual bit-banging of cfg/en.
// PARAMETERS
//   N        8    number of PAL input variables
//   M        8    number of PAL outputs
//   P        11   number of product terms (intermediate stages)
//   CFG_LEN  2*N*P+P*M (=264)  scan-chain length in bits (localparam, derived)
//   CNT_W    $clog2(CFG_LEN+1) bit-counter width (localparam, derived)
// PORTS
//   clk         in   1  single clock; all state on rising edge
//   res_n       in   1  asynchronous, active-low reset
//   start       in   1  1-cycle pulse: (re)start a load; clears counters and err
//   byte_valid  in   1  byte_data valid
//   byte_data   in   8  configuration byte, bit 0 shifted first
//   byte_ready  out  1  loader accepts a byte this cycle (valid&ready = transfer)
//   pal_cfg     out  1  serial config bit to PAL chain
//   pal_shift   out  1  chain shift enable; pal_cfg valid while high
//   pal_en      out  1  apply configuration to PAL fabric
//   busy        out  1  high in LOAD/SHIFT (and CHECK)
//   done        out  1  configuration complete and applied
//   err         out  1  sticky error (overrun; CRC mismatch with PAL_CFG_CRC_EN)
// BEHAVIOUR
//   - Reset: state=IDLE, all outputs 0, shift reg/counters 0. Async assert, sync-clean deassert.
//   - FSM: IDLE, LOAD, SHIFT, DONE (+CHECK, ERROR with macro). Outputs registered.
//   - IDLE: byte_ready=0; byte_valid ignored. start -> LOAD.
//   - LOAD: byte_ready=1, busy=1. On transfer: sreg<=byte_data, bit_idx<=0 -> SHIFT.
//   - SHIFT: byte_ready=0, pal_shift=1, pal_cfg=sreg[0]; each cycle sreg>>=1, bit_idx++, total++.
//       Leaves after bit_idx==7 or total==CFG_LEN-1 (whichever first):
//       total reaches CFG_LEN -> DONE (or CHECK); else -> LOAD. Unused bits of last byte discarded.
//   - Latency: byte accepted in cycle t -> its bits on pal_cfg in cycles t+1..t+8; max rate
//     1 byte / 9 cycles. pal_en/done rise the cycle after the CFG_LEN-th pal_shift cycle.
//   - DONE: pal_en=1, done=1, busy=0, held indefinitely. byte_valid in DONE -> err=1 (sticky),
//     byte not accepted, pal_en stays 1.
//   - start in any state (incl. mid-SHIFT): pal_en/done/err<=0, total<=0 -> LOAD next cycle;
//     partially shifted chain contents are overwritten by the new load. start wins over byte_valid.
//   - Reset mid-operation: pal_en drops asynchronously; load must be restarted from byte 0.
//   - total counter saturates at CFG_LEN; never wraps.
// CONFIGURATION
//   PAL_CFG_CRC_EN defined: after last bit FSM enters CHECK (byte_ready=1, busy=1); next accepted
//     byte is compared to CRC-8 (poly 0x07, init 0x00, MSB-first register, fed with every shifted
//     bit in chain order). Match -> DONE. Mismatch -> ERROR: err=1, pal_en=0, done=0 until start.
//   PAL_CFG_CRC_EN undefined: no CHECK/ERROR states, no CRC logic; SHIFT -> DONE directly;
//     err only from DONE overrun.
// TESTING
//   1 Assert res_n=0 mid-run -> all outputs 0 immediately; after release state IDLE, byte_ready=0.
//   2 start, 33 bytes 0xA5 back-to-back valid -> pal_cfg per byte 1,0,1,0,0,1,0,1; pal_shift high
//     264 cycles total; done=pal_en=1 one cycle after last shift; byte_ready 1 cycle per 9.
//   3 start, 10 bytes, start again -> total reset, pal_en stays 0 until 33 more bytes loaded.
//   4 In DONE drive byte_valid=1,byte_data=0xFF -> byte_ready=0, err=1, pal_en=1, no pal_shift.
//   5 byte_valid in IDLE with no start -> no transfer, pal_shift stays 0.
//   6 (PAL_CFG_CRC_EN) 33x0xA5 + model CRC -> done=1; same with CRC^0x01 -> err=1, pal_en=0.

Source files
------------

// File: rtl/pal_cfg_loader.sv
// Byte-wide loader that serialises a PAL configuration bitstream LSB-first into the scan chain.
// Optional CRC-8 trailer check is built when PAL_CFG_CRC_EN is defined.
module pal_cfg_loader #(
    parameter int N = 8,
    parameter int M = 8,
    parameter int P = 11
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       start,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       pal_cfg,
    output logic       pal_shift,
    output logic       pal_en,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CFG_LEN = 2 * N * P + P * M;
    localparam int CNT_W   = $clog2(CFG_LEN + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CFG_LEN);

`ifdef PAL_CFG_CRC_EN
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DONE, CHECK, ERROR} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
`endif

    state_t           state_q, state_d;
    logic [7:0]       sreg_q, sreg_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic             err_q, err_d;
    logic             byte_ready_q, byte_ready_d;
    logic             pal_cfg_q, pal_cfg_d;
    logic             pal_shift_q, pal_shift_d;
    logic             pal_en_q, pal_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

`ifdef PAL_CFG_CRC_EN
    logic [7:0]       crc_q, crc_d;

    // CRC-8, poly 0x07, MSB-first register, one chain bit per call
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction
`endif

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        bit_idx_d = bit_idx_q;
        total_d   = total_q;
        err_d     = err_q;
`ifdef PAL_CFG_CRC_EN
        crc_d     = crc_q;
`endif
        if (start) begin
            // restart wins over any byte offered in the same cycle
            state_d   = LOAD;
            sreg_d    = 8'h00;
            bit_idx_d = 3'd0;
            total_d   = '0;
            err_d     = 1'b0;
`ifdef PAL_CFG_CRC_EN
            crc_d     = 8'h00;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                end
                LOAD: begin
                    if (byte_valid && byte_ready_q) begin
                        sreg_d    = byte_data;
                        bit_idx_d = 3'd0;
                        state_d   = SHIFT;
                    end
                end
                SHIFT: begin
                    sreg_d    = {1'b0, sreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (total_q != FULL_CNT) begin
                        total_d = total_q + CNT_W'(1);
                    end
`ifdef PAL_CFG_CRC_EN
                    crc_d = crc8_step(crc_q, sreg_q[0]);
`endif
                    // chain full takes priority; leftover bits of the last byte are dropped
                    if (total_d == FULL_CNT) begin
`ifdef PAL_CFG_CRC_EN
                        state_d = CHECK;
`else
                        state_d = DONE;
`endif
                    end else if (bit_idx_q == 3'd7) begin
                        state_d = LOAD;
                    end
                end
                DONE: begin
                    if (byte_valid) begin
                        err_d = 1'b1;
                    end
                end
`ifdef PAL_CFG_CRC_EN
                CHECK: begin
                    if (byte_valid && byte_ready_q) begin
                        if (byte_data == crc_q) begin
                            state_d = DONE;
                        end else begin
                            state_d = ERROR;
                            err_d   = 1'b1;
                        end
                    end
                end
                ERROR: begin
                end
`endif
                default: state_d = IDLE;
            endcase
        end

        // outputs are decoded from the next state so they come straight off flops
        byte_ready_d = (state_d == LOAD);
        busy_d       = (state_d == LOAD) || (state_d == SHIFT);
`ifdef PAL_CFG_CRC_EN
        byte_ready_d = byte_ready_d || (state_d == CHECK);
        busy_d       = busy_d || (state_d == CHECK);
`endif
        pal_shift_d = (state_d == SHIFT);
        pal_cfg_d   = (state_d == SHIFT) ? sreg_d[0] : 1'b0;
        pal_en_d    = (state_d == DONE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q      <= IDLE;
            sreg_q       <= 8'h00;
            bit_idx_q    <= 3'd0;
            total_q      <= '0;
            err_q        <= 1'b0;
            byte_ready_q <= 1'b0;
            pal_cfg_q    <= 1'b0;
            pal_shift_q  <= 1'b0;
            pal_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef PAL_CFG_CRC_EN
            crc_q        <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            bit_idx_q    <= bit_idx_d;
            total_q      <= total_d;
            err_q        <= err_d;
            byte_ready_q <= byte_ready_d;
            pal_cfg_q    <= pal_cfg_d;
            pal_shift_q  <= pal_shift_d;
            pal_en_q     <= pal_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef PAL_CFG_CRC_EN
            crc_q        <= crc_d;
`endif
        end
    end

    assign byte_ready = byte_ready_q;
    assign pal_cfg    = pal_cfg_q;
    assign pal_shift  = pal_shift_q;
    assign pal_en     = pal_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
